// File: rtl/strobe_generator_multi.sv
// Multi-channel strobe generator: one shared free-running base counter, per-channel
// continuous or counted-burst strobes at a fixed (optionally staggered) phase.
//
// state | meaning
// IDLE  | channel stopped, no strobes
// CONT  | continuous run while Enable_i[k] is held
// BURST | counted run, Remaining strobes left
`timescale 1ns/1ps
module strobe_generator_multi #(
  parameter real CLOCK_HZ  = 10_000_000.0,
  parameter int  PERIOD_NS = 1000,
  parameter int  CHANNELS  = 4,
  parameter int  STAGGER   = 1,
  parameter int  BURST_W   = 8
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [CHANNELS-1:0] Enable_i,
  input  logic [CHANNELS-1:0] Start_i,
  input  logic [BURST_W-1:0]  Burst_i,
  output logic [CHANNELS-1:0] Strobe_o,
  output logic [CHANNELS-1:0] Busy_o,
  output logic [CHANNELS-1:0] Done_o
);

  localparam int TICKS = $rtoi(CLOCK_HZ * real'(PERIOD_NS) / 1.0e9 + 0.5);
  localparam int WIDTH = ($clog2(TICKS) < 1) ? 1 : $clog2(TICKS);
  localparam logic [WIDTH-1:0] LAST = WIDTH'(TICKS - 1);

  typedef enum logic [1:0] {IDLE, CONT, BURST} state_t;

  logic [WIDTH-1:0] count;

  // Never gated, so every channel stays phase-locked to the others.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)
      count <= '0;
    else if (count == LAST)
      count <= '0;
    else
      count <= count + WIDTH'(1);
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    localparam int OFF_INT = (STAGGER != 0) ? (k * TICKS) / CHANNELS : TICKS - 1;
    localparam logic [WIDTH-1:0] OFFSET = WIDTH'(OFF_INT);

    state_t             state, state_n;
    logic [BURST_W-1:0] rem, rem_n;
    logic               strobe_q, strobe_n;
    logic               done_q, done_n;
    logic               match;

    assign match = (count == OFFSET);

    always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
        state    <= IDLE;
        rem      <= '0;
        strobe_q <= 1'b0;
        done_q   <= 1'b0;
      end else begin
        state    <= state_n;
        rem      <= rem_n;
        strobe_q <= strobe_n;
        done_q   <= done_n;
      end
    end

    always_comb begin
      state_n  = state;
      rem_n    = rem;
      strobe_n = 1'b0;
      done_n   = 1'b0;
      unique case (state)
        IDLE: begin
          if (Enable_i[k]) begin
            state_n = CONT;
          end else if (Start_i[k]) begin
            if (Burst_i != '0) begin
              state_n = BURST;
              rem_n   = Burst_i;
            end else begin
              done_n = 1'b1;
            end
          end
        end
        CONT: begin
          if (!Enable_i[k])
            state_n = IDLE;
          else
            strobe_n = match;
        end
        BURST: begin
          // Enable overrides a running burst; the burst is abandoned without Done.
          if (Enable_i[k]) begin
            state_n  = CONT;
            strobe_n = match;
          end else if (match) begin
            strobe_n = 1'b1;
            rem_n    = rem - BURST_W'(1);
            if (rem == BURST_W'(1)) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end

    assign Strobe_o[k] = strobe_q;
    assign Done_o[k]   = done_q;
    assign Busy_o[k]   = (state != IDLE);
  end

endmodule

// File: tb/tb_strobe_generator_multi.sv
// Bench for strobe_generator_multi: directed scenarios plus random traffic, checked
// cycle by cycle against a behavioural channel model and scenario-level tallies.
`timescale 1ns/1ps
module tb_strobe_generator_multi;
  localparam int CH    = 4;
  localparam int TICKS = 10;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic [CH-1:0] Enable_i = '0;
  logic [CH-1:0] Start_i  = '0;
  logic [7:0]    Burst_i  = '0;
  logic [CH-1:0] Strobe_o, Busy_o, Done_o;

  strobe_generator_multi #(
    .CLOCK_HZ(10_000_000.0), .PERIOD_NS(1000), .CHANNELS(CH), .STAGGER(1), .BURST_W(8)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Enable_i(Enable_i), .Start_i(Start_i),
    .Burst_i(Burst_i), .Strobe_o(Strobe_o), .Busy_o(Busy_o), .Done_o(Done_o)
  );

  always #50 Clock = ~Clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 continuous, 2 burst; phase = cycles since release mod TICKS.
  int            off[CH];
  int            m_mode[CH];
  int            m_rem[CH];
  int            m_phase;
  logic [CH-1:0] e_strobe, e_busy, e_done;

  int n_str[CH], n_dn[CH], t_last[CH], t_prev[CH];
  int cyc_no = 0;

  task automatic model_reset();
    m_phase = 0;
    for (int k = 0; k < CH; k++) begin
      m_mode[k] = 0;
      m_rem[k]  = 0;
    end
    e_strobe = '0; e_busy = '0; e_done = '0;
  endtask

  task automatic model_step(input logic [CH-1:0] en, input logic [CH-1:0] st, input int b);
    for (int k = 0; k < CH; k++) begin
      bit hit;
      hit = (m_phase == off[k]);
      e_strobe[k] = 1'b0;
      e_done[k]   = 1'b0;
      if (m_mode[k] == 0) begin
        if (en[k]) m_mode[k] = 1;
        else if (st[k] && b != 0) begin m_mode[k] = 2; m_rem[k] = b; end
        else if (st[k]) e_done[k] = 1'b1;
      end else if (m_mode[k] == 1) begin
        if (!en[k]) m_mode[k] = 0;
        else e_strobe[k] = hit;
      end else begin
        if (en[k]) begin m_mode[k] = 1; e_strobe[k] = hit; end
        else if (hit) begin
          e_strobe[k] = 1'b1;
          m_rem[k]--;
          if (m_rem[k] == 0) begin m_mode[k] = 0; e_done[k] = 1'b1; end
        end
      end
      e_busy[k] = (m_mode[k] != 0);
    end
    m_phase = (m_phase + 1) % TICKS;
  endtask

  task automatic clear_tally();
    for (int k = 0; k < CH; k++) begin
      n_str[k] = 0; n_dn[k] = 0; t_last[k] = 0; t_prev[k] = 0;
    end
  endtask

  // Called at a falling edge: drive, advance model, sample at the next falling edge.
  task automatic cyc(input logic [CH-1:0] en, input logic [CH-1:0] st, input int b);
    Enable_i = en; Start_i = st; Burst_i = 8'(b);
    model_step(en, st, b);
    @(negedge Clock);
    cyc_no++;
    check_val("strobe", 32'(Strobe_o), 32'(e_strobe));
    check_val("busy",   32'(Busy_o),   32'(e_busy));
    check_val("done",   32'(Done_o),   32'(e_done));
    for (int k = 0; k < CH; k++) begin
      if (Strobe_o[k]) begin n_str[k]++; t_prev[k] = t_last[k]; t_last[k] = cyc_no; end
      if (Done_o[k]) n_dn[k]++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    logic [CH-1:0] r_en, r_st;
    int sum;
    for (int k = 0; k < CH; k++) off[k] = (k * TICKS) / CH;
    model_reset();
    clear_tally();

    // 1: reset and idle
    Reset = 1'b1;
    repeat (3) @(negedge Clock);
    check_val("rst_strobe", 32'(Strobe_o), 0);
    check_val("rst_busy",   32'(Busy_o),   0);
    check_val("rst_done",   32'(Done_o),   0);
    Reset = 1'b0;
    repeat (30) cyc('0, '0, 0);
    sum = 0;
    for (int k = 0; k < CH; k++) sum += n_str[k] + n_dn[k];
    check_val("s1_idle_activity", sum, 0);

    // 2: all channels continuous, period and stagger
    clear_tally();
    repeat (45) cyc(4'hF, '0, 0);
    for (int k = 0; k < CH; k++) begin
      check_val($sformatf("s2_period_ch%0d", k), t_last[k] - t_prev[k], TICKS);
      check_val($sformatf("s2_phase_ch%0d", k), ((t_last[k] - t_last[0]) % TICKS + TICKS) % TICKS, off[k]);
    end
    clear_tally();
    repeat (20) cyc('0, '0, 0);
    sum = 0;
    for (int k = 0; k < CH; k++) sum += n_str[k];
    check_val("s2_stop_strobes", sum, 0);

    // 3: burst of 3 on ch2, restart attempt mid-burst ignored
    clear_tally();
    cyc('0, 4'b0100, 3);
    repeat (15) cyc('0, '0, 0);
    cyc('0, 4'b0100, 7);
    repeat (40) cyc('0, '0, 0);
    check_val("s3_strobes", n_str[2], 3);
    check_val("s3_done", n_dn[2], 1);
    check_val("s3_gap", t_last[2] - t_prev[2], TICKS);
    check_val("s3_busy_end", 32'(Busy_o[2]), 0);

    // 4: zero-length burst on ch1
    clear_tally();
    cyc('0, 4'b0010, 0);
    check_val("s4_done_next", 32'(Done_o[1]), 1);
    repeat (15) cyc('0, '0, 0);
    check_val("s4_strobes", n_str[1], 0);
    check_val("s4_done_cnt", n_dn[1], 1);

    // 5: burst of 5 on ch0 overridden by enable after 2nd strobe
    clear_tally();
    cyc('0, 4'b0001, 5);
    for (int i = 0; i < 40 && n_str[0] < 2; i++) cyc('0, '0, 0);
    check_val("s5_reach_two", n_str[0], 2);
    clear_tally();
    repeat (30) cyc(4'b0001, '0, 0);
    check_val("s5_cont_strobes", n_str[0], 3);
    check_val("s5_no_done", n_dn[0], 0);
    clear_tally();
    repeat (20) cyc('0, '0, 0);
    check_val("s5_after_stop", n_str[0] + n_dn[0], 0);

    // 6: asynchronous reset mid-burst on ch3
    clear_tally();
    cyc('0, 4'b1000, 4);
    repeat (15) cyc('0, '0, 0);
    @(posedge Clock);
    #2 Reset = 1'b1;
    #1;
    check_val("s6_async_strobe", 32'(Strobe_o), 0);
    check_val("s6_async_busy",   32'(Busy_o),   0);
    check_val("s6_async_done",   32'(Done_o),   0);
    model_reset();
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    clear_tally();
    repeat (30) cyc('0, '0, 0);
    check_val("s6_post_strobes", n_str[3], 0);
    check_val("s6_post_done", n_dn[3], 0);

    // random traffic
    r_en = '0;
    repeat (800) begin
      r_st = '0;
      for (int k = 0; k < CH; k++) begin
        if ($urandom_range(0, 29) == 0) r_en[k] = ~r_en[k];
        if ($urandom_range(0, 7) == 0) r_st[k] = 1'b1;
      end
      cyc(r_en, r_st, int'($urandom_range(0, 6)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
